// File: rtl/pc_fetch.sv
// Instruction fetch stage: one outstanding bus request, a single-entry output
// buffer to IF/ID, and flush/mret/branch redirects with in-flight response discard.
module pc_fetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RST_ADDR = '0,
  parameter logic [XLEN-1:0] NOP_INST = XLEN'(32'h0000_0013)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pipe_stall,
  input  logic            pipe_flush,
  input  logic [XLEN-1:0] flush_pc,
  input  logic            ex_bj_flag,
  input  logic [XLEN-1:0] ex_bj_pc,
  input  logic            ex_is_mret_inst,
  input  logic [XLEN-1:0] mret_pc,
  input  logic            int_req,
  output logic            ibus_req,
  output logic [XLEN-1:0] ibus_addr,
  input  logic            ibus_gnt,
  input  logic            ibus_rvalid,
  input  logic [XLEN-1:0] ibus_rdata,
  input  logic            ibus_err,
  input  logic            id_allowin,
  output logic            if_out_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_inst,
  output logic            if_int_flag,
  output logic            if_exp_flag,
  output logic            if_inst_addr_misal
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t          r_state, w_nxt_state;
  logic [XLEN-1:0] r_pc, w_nxt_pc;
  logic            r_discard, w_nxt_discard;
  logic            r_fault, w_nxt_fault;
  logic            r_valid, r_int, r_exp, r_misal;
  logic [XLEN-1:0] r_if_pc, r_inst;

  logic            w_redirect, w_accept, w_misal, w_fire;
  logic [XLEN-1:0] w_redir_pc;
  logic            w_load, w_ld_exp, w_ld_misal;
  logic [XLEN-1:0] w_ld_inst;

  assign w_redirect = pipe_flush | ex_is_mret_inst | ex_bj_flag;
  assign w_redir_pc = pipe_flush      ? flush_pc :
                      ex_is_mret_inst ? mret_pc  : ex_bj_pc;
  assign w_accept   = r_valid & id_allowin & ~pipe_stall;
  assign w_misal    = |r_pc[1:0];

  // Request only when the buffer will be free by the time the response lands.
  assign ibus_req  = rst_n & (r_state == S_REQ) & ~w_misal & (~r_valid | w_accept);
  assign ibus_addr = r_pc;
  assign w_fire    = ibus_req & ibus_gnt;

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_pc      = r_pc;
    w_nxt_discard = r_discard;
    w_nxt_fault   = r_fault;
    w_load        = 1'b0;
    w_ld_inst     = ibus_rdata;
    w_ld_exp      = 1'b0;
    w_ld_misal    = 1'b0;
    case (r_state)
      S_REQ: begin
        if (w_redirect) begin
          w_nxt_pc      = w_redir_pc;
          w_nxt_fault   = 1'b0;
          // A grant this cycle leaves a response in flight that must be dropped.
          w_nxt_state   = w_fire ? S_WAIT : S_REQ;
          w_nxt_discard = w_fire;
        end else if (w_misal) begin
          w_load      = 1'b1;
          w_ld_inst   = NOP_INST;
          w_ld_exp    = 1'b1;
          w_ld_misal  = 1'b1;
          w_nxt_fault = 1'b1;
          w_nxt_state = S_HOLD;
        end else if (w_fire) begin
          w_nxt_state = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ibus_rvalid) begin
          if (r_discard || w_redirect) begin
            w_nxt_discard = 1'b0;
            w_nxt_state   = S_REQ;
            if (w_redirect) w_nxt_pc = w_redir_pc;
          end else if (ibus_err) begin
            w_load      = 1'b1;
            w_ld_inst   = NOP_INST;
            w_ld_exp    = 1'b1;
            w_nxt_fault = 1'b1;
            w_nxt_state = S_HOLD;
          end else begin
            w_load      = 1'b1;
            w_nxt_pc    = r_pc + XLEN'(4);
            w_nxt_state = w_accept ? S_REQ : S_HOLD;
          end
        end else if (w_redirect) begin
          w_nxt_pc      = w_redir_pc;
          w_nxt_discard = 1'b1;
        end
      end
      S_HOLD: begin
        if (w_redirect) begin
          w_nxt_pc    = w_redir_pc;
          w_nxt_fault = 1'b0;
          w_nxt_state = S_REQ;
        end else if (w_accept && !r_fault) begin
          w_nxt_state = S_REQ;
        end
      end
      default: w_nxt_state = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_REQ;
      r_pc      <= RST_ADDR;
      r_discard <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_pc      <= w_nxt_pc;
      r_discard <= w_nxt_discard;
      r_fault   <= w_nxt_fault;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_if_pc <= RST_ADDR;
      r_inst  <= NOP_INST;
      r_int   <= 1'b0;
      r_exp   <= 1'b0;
      r_misal <= 1'b0;
    end else if (w_redirect) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_if_pc <= r_pc;
      r_inst  <= w_ld_inst;
      r_int   <= int_req;
      r_exp   <= w_ld_exp;
      r_misal <= w_ld_misal;
    end else if (w_accept) begin
      r_valid <= 1'b0;
    end
  end

  assign if_out_valid       = r_valid;
  assign if_pc              = r_if_pc;
  assign if_inst            = r_inst;
  assign if_int_flag        = r_int;
  assign if_exp_flag        = r_exp;
  assign if_inst_addr_misal = r_misal;
endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch with a small latency-programmable instruction bus model.
module tb_pc_fetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pipe_stall = 0, pipe_flush = 0, ex_bj_flag = 0, ex_is_mret_inst = 0, int_req = 0;
  logic [31:0] flush_pc = '0, ex_bj_pc = '0, mret_pc = '0;
  logic        ibus_req, ibus_gnt, ibus_rvalid = 0, ibus_err = 0;
  logic [31:0] ibus_addr, ibus_rdata = '0;
  logic        id_allowin = 1;
  logic        if_out_valid, if_int_flag, if_exp_flag, if_inst_addr_misal;
  logic [31:0] if_pc, if_inst;

  int n_chk = 0, n_fail = 0;
  int lat = 1, req_cnt = 0, base;
  logic        gnt_en = 1;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  logic        samp_fire = 0, pend = 0;
  logic [31:0] samp_addr = '0, paddr = '0;
  int          pcnt = 0;

  pc_fetch dut (
    .clk(clk), .rst_n(rst_n), .pipe_stall(pipe_stall), .pipe_flush(pipe_flush),
    .flush_pc(flush_pc), .ex_bj_flag(ex_bj_flag), .ex_bj_pc(ex_bj_pc),
    .ex_is_mret_inst(ex_is_mret_inst), .mret_pc(mret_pc), .int_req(int_req),
    .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_gnt(ibus_gnt),
    .ibus_rvalid(ibus_rvalid), .ibus_rdata(ibus_rdata), .ibus_err(ibus_err),
    .id_allowin(id_allowin), .if_out_valid(if_out_valid), .if_pc(if_pc), .if_inst(if_inst),
    .if_int_flag(if_int_flag), .if_exp_flag(if_exp_flag), .if_inst_addr_misal(if_inst_addr_misal)
  );

  always #5 clk = ~clk;

  // Bus: grant combinational, response 'lat' cycles after the grant cycle, data = C0DE0000|addr.
  assign ibus_gnt = ibus_req & gnt_en;

  always @(negedge clk) begin
    samp_fire = rst_n & ibus_req & ibus_gnt;
    samp_addr = ibus_addr;
    if (samp_fire) req_cnt++;
  end

  always @(posedge clk) begin
    #1;
    ibus_rvalid = 1'b0;
    ibus_err    = 1'b0;
    if (!rst_n) pend = 1'b0;
    else begin
      if (samp_fire) begin pend = 1'b1; pcnt = lat; paddr = samp_addr; end
      if (pend) begin
        if (pcnt <= 1) begin
          ibus_rvalid = 1'b1;
          ibus_rdata  = 32'hC0DE_0000 | paddr;
          ibus_err    = (paddr == err_addr);
          pend        = 1'b0;
        end else pcnt--;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (!if_out_valid && n < 40);
    chk({tag, " vld"}, {31'b0, if_out_valid}, 32'd1);
  endtask

  task automatic wait_req(input string tag, output logic saw_vld);
    int n = 0;
    saw_vld = 1'b0;
    do begin @(negedge clk); n++; saw_vld |= if_out_valid; end while (!ibus_req && n < 40);
    chk({tag, " req"}, {31'b0, ibus_req}, 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic redirect(input logic fl, input logic mr, input logic bj,
                          input logic [31:0] fpc, input logic [31:0] mpc, input logic [31:0] bpc);
    @(posedge clk); #1;
    pipe_flush = fl; ex_is_mret_inst = mr; ex_bj_flag = bj;
    flush_pc = fpc; mret_pc = mpc; ex_bj_pc = bpc;
    @(posedge clk); #1;
    pipe_flush = 0; ex_is_mret_inst = 0; ex_bj_flag = 0;
  endtask

  initial begin
    logic saw;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst vld",  {31'b0, if_out_valid}, 0);
    chk("rst req",  {31'b0, ibus_req}, 0);
    chk("rst pc",   if_pc, 32'h0);
    chk("rst inst", if_inst, 32'h13);
    chk("rst flags", {29'b0, if_int_flag, if_exp_flag, if_inst_addr_misal}, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // In-order fetch 0x0, 0x4, 0x8, one request per word
    base = req_cnt;
    @(negedge clk);
    chk("t1 req0", {31'b0, ibus_req}, 1);
    chk("t1 addr0", ibus_addr, 32'h0);
    for (int i = 0; i < 3; i++) begin
      wait_valid("t1");
      chk("t1 pc", if_pc, 32'(4 * i));
      chk("t1 inst", if_inst, 32'hC0DE_0000 | 32'(4 * i));
    end
    chk("t1 reqcnt", 32'(req_cnt - base), 32'd3);

    // Downstream back-pressure and stall hold the buffer
    do_reset();
    id_allowin = 0;
    wait_valid("t2");
    for (int i = 0; i < 5; i++) begin
      chk("t2 hold pc", if_pc, 32'h0);
      chk("t2 hold inst", if_inst, 32'hC0DE_0000);
      chk("t2 hold req", {31'b0, ibus_req}, 0);
      @(negedge clk);
    end
    id_allowin = 1; pipe_stall = 1;
    repeat (2) @(negedge clk);
    chk("t2 stall vld", {31'b0, if_out_valid}, 1);
    chk("t2 stall pc", if_pc, 32'h0);
    pipe_stall = 0;
    wait_valid("t2 resume");
    chk("t2 resume pc", if_pc, 32'h4);

    // Branch while waiting on 0x8: response dropped, refetch from 0x100
    do_reset();
    lat = 3;
    wait_valid("t3a"); chk("t3 pc0", if_pc, 32'h0);
    wait_valid("t3b"); chk("t3 pc4", if_pc, 32'h4);
    wait_req("t3 r8", saw);
    chk("t3 addr8", ibus_addr, 32'h8);
    redirect(0, 0, 1, 0, 0, 32'h100);
    wait_req("t3 r100", saw);
    chk("t3 drop8", {31'b0, saw}, 0);
    chk("t3 addr100", ibus_addr, 32'h100);
    wait_valid("t3c");
    chk("t3 pc100", if_pc, 32'h100);
    chk("t3 inst100", if_inst, 32'hC0DE_0100);
    lat = 1;

    // Redirect priority while request is not granted
    gnt_en = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4 stuck addr", ibus_addr, 32'h104);
    redirect(1, 0, 1, 32'h200, 0, 32'h300);
    chk("t4 flush addr", ibus_addr, 32'h200);
    redirect(0, 1, 1, 0, 32'h400, 32'h300);
    chk("t4 mret addr", ibus_addr, 32'h400);
    gnt_en = 1;
    wait_valid("t4");
    chk("t4 pc400", if_pc, 32'h400);
    chk("t4 inst400", if_inst, 32'hC0DE_0400);
    gnt_en = 0;

    // Misaligned branch target
    redirect(0, 0, 1, 0, 0, 32'h102);
    @(negedge clk);
    chk("t5 no req", {31'b0, ibus_req}, 0);
    wait_valid("t5");
    chk("t5 pc", if_pc, 32'h102);
    chk("t5 inst", if_inst, 32'h13);
    chk("t5 flags", {29'b0, if_int_flag, if_exp_flag, if_inst_addr_misal}, 32'b011);
    repeat (3) @(negedge clk);
    chk("t5 held req", {31'b0, ibus_req}, 0);

    // Bus error with pending interrupt
    gnt_en = 1; err_addr = 32'h10; int_req = 1;
    redirect(0, 0, 1, 0, 0, 32'h10);
    wait_valid("t6");
    chk("t6 pc", if_pc, 32'h10);
    chk("t6 inst", if_inst, 32'h13);
    chk("t6 flags", {29'b0, if_int_flag, if_exp_flag, if_inst_addr_misal}, 32'b110);
    repeat (4) @(negedge clk);
    chk("t6 held req", {31'b0, ibus_req}, 0);
    chk("t6 held vld", {31'b0, if_out_valid}, 0);
    int_req = 0;
    redirect(0, 0, 1, 0, 0, 32'h20);
    wait_valid("t6 rec");
    chk("t6 rec pc", if_pc, 32'h20);
    chk("t6 rec inst", if_inst, 32'hC0DE_0020);
    chk("t6 rec flags", {29'b0, if_int_flag, if_exp_flag, if_inst_addr_misal}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
